// File: rtl/i2c_apb_cfg_sequencer.sv
// APB master that programs the I2C APB slave (TIMEOUT, CONFIG) and then
// streams a burst of TX words, throttled by INT_TX, aborting on PSLVERR or PREADY watchdog.
module i2c_apb_cfg_sequencer #(
   parameter int unsigned LEN_W    = 8,
   parameter int unsigned WDOG_W   = 8,
   parameter int unsigned WDOG_MAX = 200
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              start,
   input  logic [13:0]       cfg_value,
   input  logic [13:0]       tmo_value,
   input  logic [LEN_W-1:0]  word_count,
   input  logic [31:0]       data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [15:0]       PADDR,
   output logic [31:0]       PWDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   input  logic              INT_TX,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 14;

   localparam logic [ADDR_W-1:0] ADDR_TX  = 16'h0000;
   localparam logic [ADDR_W-1:0] ADDR_CFG = 16'h0004;
   localparam logic [ADDR_W-1:0] ADDR_TMO = 16'h0008;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_SLV  = 2'd1;
   localparam logic [1:0] ERR_WDOG = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ACCESS, S_WAIT_DATA, S_DONE, S_ERR
   } state_t;

   typedef enum logic [1:0] {
      STEP_TMO, STEP_CFG, STEP_DATA
   } step_t;

   state_t              state, state_n;
   step_t               step, step_n;
   logic [REG_W-1:0]    cfg_q, cfg_n;
   logic [REG_W-1:0]    tmo_q, tmo_n;
   logic [LEN_W-1:0]    cnt_q, cnt_n;
   logic [WDOG_W-1:0]   wdog_q, wdog_n;
   logic [DATA_W-1:0]   word_q, word_n;

   logic                psel_n, penable_n, pwrite_n;
   logic [ADDR_W-1:0]   paddr_n;
   logic [DATA_W-1:0]   pwdata_n;
   logic                data_ready_n, busy_n, done_n, err_n;
   logic [1:0]          err_code_n;

   // State, datapath and registered outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state      <= S_IDLE;
         step       <= STEP_TMO;
         cfg_q      <= '0;
         tmo_q      <= '0;
         cnt_q      <= '0;
         wdog_q     <= '0;
         word_q     <= '0;
         PSELx      <= 1'b0;
         PENABLE    <= 1'b0;
         PWRITE     <= 1'b0;
         PADDR      <= '0;
         PWDATA     <= '0;
         data_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= ERR_NONE;
      end else begin
         state      <= state_n;
         step       <= step_n;
         cfg_q      <= cfg_n;
         tmo_q      <= tmo_n;
         cnt_q      <= cnt_n;
         wdog_q     <= wdog_n;
         word_q     <= word_n;
         PSELx      <= psel_n;
         PENABLE    <= penable_n;
         PWRITE     <= pwrite_n;
         PADDR      <= paddr_n;
         PWDATA     <= pwdata_n;
         data_ready <= data_ready_n;
         busy       <= busy_n;
         done       <= done_n;
         err        <= err_n;
         err_code   <= err_code_n;
      end
   end

   // Next state; outputs are decoded from the next state so they register in step with it
   always_comb begin
      state_n      = state;
      step_n       = step;
      cfg_n        = cfg_q;
      tmo_n        = tmo_q;
      cnt_n        = cnt_q;
      wdog_n       = wdog_q;
      word_n       = word_q;
      err_code_n   = err_code;
      data_ready_n = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               cfg_n      = cfg_value;
               tmo_n      = tmo_value;
               cnt_n      = word_count;
               err_code_n = ERR_NONE;
               step_n     = STEP_TMO;
               wdog_n     = '0;
               state_n    = S_SETUP;
            end
         end
         S_SETUP: state_n = S_ACCESS;
         S_ACCESS: begin
            if (PREADY) begin
               if (PSLVERR) begin
                  err_code_n = ERR_SLV;
                  state_n    = S_ERR;
               end else begin
                  case (step)
                     STEP_TMO: begin
                        step_n  = STEP_CFG;
                        wdog_n  = '0;
                        state_n = S_SETUP;
                     end
                     STEP_CFG: state_n = (cnt_q == '0) ? S_DONE : S_WAIT_DATA;
                     STEP_DATA: begin
                        cnt_n   = cnt_q - LEN_W'(1);
                        state_n = (cnt_q == LEN_W'(1)) ? S_DONE : S_WAIT_DATA;
                     end
                     default: state_n = S_IDLE;
                  endcase
               end
            end else if (wdog_q == WDOG_W'(WDOG_MAX)) begin
               err_code_n = ERR_WDOG;
               state_n    = S_ERR;
            end else begin
               wdog_n = wdog_q + WDOG_W'(1);
            end
         end
         S_WAIT_DATA: begin
            if (data_valid && INT_TX) begin
               data_ready_n = 1'b1;
               word_n       = data_in;
               step_n       = STEP_DATA;
               wdog_n       = '0;
               state_n      = S_SETUP;
            end
         end
         S_DONE:  state_n = S_IDLE;
         S_ERR:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      psel_n    = (state_n == S_SETUP) || (state_n == S_ACCESS);
      penable_n = (state_n == S_ACCESS);
      pwrite_n  = psel_n;
      busy_n    = (state_n != S_IDLE);
      done_n    = (state_n == S_DONE);
      err_n     = (state_n == S_ERR);
      paddr_n   = PADDR;
      pwdata_n  = PWDATA;

      // Address/data are loaded only on SETUP entry and held through ACCESS
      if (state_n == S_SETUP) begin
         case (step_n)
            STEP_TMO: begin
               paddr_n  = ADDR_TMO;
               pwdata_n = DATA_W'(tmo_n);
            end
            STEP_CFG: begin
               paddr_n  = ADDR_CFG;
               pwdata_n = DATA_W'(cfg_n);
            end
            default: begin
               paddr_n  = ADDR_TX;
               pwdata_n = word_n;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_apb_cfg_sequencer.sv
// Scoreboard bench for i2c_apb_cfg_sequencer: stimulus queues expected APB writes,
// a negedge monitor models the APB slave and pops/compares each completed write.
module tb_i2c_apb_cfg_sequencer;

   localparam int unsigned LEN_W    = 8;
   localparam int unsigned WDOG_W   = 8;
   localparam int unsigned WDOG_MAX = 200;

   logic              PCLK = 1'b0;
   logic              PRESET = 1'b1;
   logic              start = 1'b0;
   logic [13:0]       cfg_value = '0;
   logic [13:0]       tmo_value = '0;
   logic [LEN_W-1:0]  word_count = '0;
   logic [31:0]       data_in = '0;
   logic              data_valid = 1'b0;
   logic              data_ready;
   logic              PSELx, PENABLE, PWRITE;
   logic [15:0]       PADDR;
   logic [31:0]       PWDATA;
   logic              PREADY = 1'b0;
   logic              PSLVERR = 1'b0;
   logic              INT_TX = 1'b1;
   logic              busy, done, err;
   logic [1:0]        err_code;

   i2c_apb_cfg_sequencer #(.LEN_W(LEN_W), .WDOG_W(WDOG_W), .WDOG_MAX(WDOG_MAX)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .start(start), .cfg_value(cfg_value),
      .tmo_value(tmo_value), .word_count(word_count), .data_in(data_in),
      .data_valid(data_valid), .data_ready(data_ready), .PSELx(PSELx),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .INT_TX(INT_TX), .busy(busy),
      .done(done), .err(err), .err_code(err_code)
   );

   always #5 PCLK = ~PCLK;

   typedef struct { logic [15:0] a; logic [31:0] d; } apb_t;
   apb_t exp_q[$];

   int checks = 0;
   int failures = 0;

   // slave model controls
   logic        hang = 1'b0;
   logic [15:0] stall_addr = 16'hFFFF;
   int          stall_n = 0;
   int          stall_cnt = 0;
   logic        err_en = 1'b0;
   logic [31:0] err_word = '0;

   // monitor state
   logic [15:0] cap_a = '0;
   logic [31:0] cap_d = '0;
   int          acc_cnt = 0;
   int          cfg_acc_len = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          dr_total = 0;
   logic        prev_int_tx = 1'b1;
   apb_t        mon_t;

   // source model
   logic [31:0] src_words [4];
   int          src_base = 0;
   int          src_idx = 0;
   logic        itx_toggle = 1'b0;
   int          itx_low = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endfunction

   // APB slave response plus scoreboard monitor
   always @(negedge PCLK) begin
      if (PSELx === 1'b1 && PENABLE === 1'b1) begin
         if (hang) PREADY = 1'b0;
         else if (PADDR == stall_addr && stall_cnt < stall_n) begin
            PREADY = 1'b0;
            stall_cnt++;
         end else PREADY = 1'b1;
         PSLVERR = PREADY && err_en && (PADDR == 16'h0000) && (PWDATA == err_word);
      end else begin
         PREADY = 1'b0;
         PSLVERR = 1'b0;
         stall_cnt = 0;
      end

      if (PSELx === 1'b1) chk("pwrite_high", 32'(PWRITE), 32'd1);
      if (PSELx === 1'b1 && PENABLE === 1'b0) begin
         cap_a = PADDR;
         cap_d = PWDATA;
         acc_cnt = 0;
         if (PADDR == 16'h0000) chk("data_setup_int_tx", 32'(prev_int_tx), 32'd1);
      end
      if (PSELx === 1'b1 && PENABLE === 1'b1) begin
         acc_cnt++;
         chk("paddr_stable", 32'(PADDR), 32'(cap_a));
         chk("pwdata_stable", PWDATA, cap_d);
         if (PREADY) begin
            if (PADDR == 16'h0004) cfg_acc_len = acc_cnt;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_apb_write addr=0x%0h data=0x%0h expected=none", PADDR, PWDATA);
            end else begin
               mon_t = exp_q.pop_front();
               chk("apb_addr", 32'(PADDR), 32'(mon_t.a));
               chk("apb_data", PWDATA, mon_t.d);
            end
         end
      end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
      if (data_ready === 1'b1) dr_total++;
      prev_int_tx = INT_TX;
   end

   // Data source: advances on data_ready; optionally drops INT_TX for 4 cycles per word
   always @(posedge PCLK) begin
      #1;
      if (itx_toggle && data_ready) itx_low = 4;
      if (itx_low > 0) begin
         INT_TX = 1'b0;
         itx_low--;
      end else INT_TX = 1'b1;
      src_idx = dr_total - src_base;
      data_in = (src_idx >= 0 && src_idx < 4) ? src_words[src_idx] : 32'hDEAD_BEEF;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [31:0] d);
      apb_t t;
      t.a = a;
      t.d = d;
      exp_q.push_back(t);
   endtask

   task automatic start_run(input logic [13:0] tmo, input logic [13:0] cfg, input logic [LEN_W-1:0] cnt);
      tmo_value = tmo;
      cfg_value = cfg;
      word_count = cnt;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_end(input int max, output int cyc);
      cyc = 0;
      while (done !== 1'b1 && err !== 1'b1 && cyc < max) begin
         tick(1);
         cyc++;
      end
      if (done !== 1'b1 && err !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL wait_end_timeout cycles=%0d limit=%0d", cyc, max);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int d0, dr0, e0;

      // reset state
      tick(3);
      chk("rst_psel", 32'(PSELx), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_pwrite", 32'(PWRITE), 32'd0);
      chk("rst_paddr", 32'(PADDR), 32'd0);
      chk("rst_pwdata", PWDATA, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done_err", 32'({done, err, data_ready}), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      PRESET = 1'b0;
      tick(2);

      // configure only
      dr0 = dr_total;
      push(16'h0008, 32'h0000_0123);
      push(16'h0004, 32'h0000_0A5F);
      start_run(14'h0123, 14'h0A5F, '0);
      chk("cfg_busy_after_start", 32'(busy), 32'd1);
      wait_end(50, cyc);
      chk("cfg_only_start_to_done", 32'(cyc + 2), 32'd6);
      chk("cfg_only_done", 32'(done), 32'd1);
      chk("cfg_only_no_data_ready", 32'(dr_total - dr0), 32'd0);
      tick(1);
      chk("cfg_only_busy_low", 32'(busy), 32'd0);
      chk("cfg_only_done_1cyc", 32'(done), 32'd0);
      chk("cfg_only_q_empty", 32'(exp_q.size()), 32'd0);

      // burst of 3 with INT_TX throttling
      src_words[0] = 32'h11; src_words[1] = 32'h22; src_words[2] = 32'h33; src_words[3] = 32'h44;
      src_base = dr_total;
      dr0 = dr_total;
      itx_toggle = 1'b1;
      data_valid = 1'b1;
      push(16'h0008, 32'h0000_0077);
      push(16'h0004, 32'h0000_1234);
      push(16'h0000, 32'h11);
      push(16'h0000, 32'h22);
      push(16'h0000, 32'h33);
      start_run(14'h0077, 14'h1234, 8'd3);
      wait_end(300, cyc);
      chk("burst_done", 32'(done), 32'd1);
      chk("burst_busy_with_done", 32'(busy), 32'd1);
      chk("burst_data_ready_cnt", 32'(dr_total - dr0), 32'd3);
      chk("burst_q_empty", 32'(exp_q.size()), 32'd0);
      tick(1);
      chk("burst_busy_falls", 32'(busy), 32'd0);
      data_valid = 1'b0;
      itx_toggle = 1'b0;
      tick(6);

      // CFG write stalled 5 cycles
      src_words[0] = 32'hCAFE_0001;
      src_base = dr_total;
      stall_addr = 16'h0004;
      stall_n = 5;
      data_valid = 1'b1;
      push(16'h0008, 32'h0000_0010);
      push(16'h0004, 32'h0000_0020);
      push(16'h0000, 32'hCAFE_0001);
      start_run(14'h0010, 14'h0020, 8'd1);
      wait_end(100, cyc);
      chk("stall_done", 32'(done), 32'd1);
      chk("stall_cfg_access_cycles", 32'(cfg_acc_len), 32'd6);
      chk("stall_q_empty", 32'(exp_q.size()), 32'd0);
      stall_n = 0;
      data_valid = 1'b0;
      tick(3);

      // PREADY watchdog on the TMO write
      d0 = done_cnt;
      hang = 1'b1;
      start_run(14'h0001, 14'h0002, '0);
      wait_end(400, cyc);
      chk("wdog_err", 32'(err), 32'd1);
      chk("wdog_err_code", 32'(err_code), 32'd2);
      chk("wdog_access_cycles", 32'(acc_cnt), 32'(WDOG_MAX + 1));
      chk("wdog_psel_low", 32'(PSELx), 32'd0);
      tick(1);
      chk("wdog_err_1cyc", 32'(err), 32'd0);
      chk("wdog_code_held", 32'(err_code), 32'd2);
      chk("wdog_no_done", 32'(done_cnt - d0), 32'd0);
      hang = 1'b0;
      tick(2);

      // PSLVERR on the second data word
      src_words[0] = 32'h11; src_words[1] = 32'h22; src_words[2] = 32'h33;
      src_base = dr_total;
      dr0 = dr_total;
      d0 = done_cnt;
      e0 = err_cnt;
      err_en = 1'b1;
      err_word = 32'h22;
      data_valid = 1'b1;
      push(16'h0008, 32'h0000_0005);
      push(16'h0004, 32'h0000_0006);
      push(16'h0000, 32'h11);
      push(16'h0000, 32'h22);
      start_run(14'h0005, 14'h0006, 8'd3);
      wait_end(100, cyc);
      chk("slverr_err", 32'(err), 32'd1);
      chk("slverr_code", 32'(err_code), 32'd1);
      tick(10);
      chk("slverr_words_taken", 32'(dr_total - dr0), 32'd2);
      chk("slverr_no_done", 32'(done_cnt - d0), 32'd0);
      chk("slverr_one_err", 32'(err_cnt - e0), 32'd1);
      chk("slverr_q_empty", 32'(exp_q.size()), 32'd0);
      err_en = 1'b0;
      data_valid = 1'b0;
      push(16'h0008, 32'h0000_0009);
      push(16'h0004, 32'h0000_000A);
      start_run(14'h0009, 14'h000A, '0);
      chk("restart_clears_code", 32'(err_code), 32'd0);
      wait_end(50, cyc);
      chk("restart_done", 32'(done), 32'd1);
      tick(2);

      // reset during a data ACCESS
      src_words[0] = 32'h55; src_words[1] = 32'h66;
      src_base = dr_total;
      d0 = done_cnt;
      stall_addr = 16'h0000;
      stall_n = 10;
      data_valid = 1'b1;
      push(16'h0008, 32'h0000_0100);
      push(16'h0004, 32'h0000_0200);
      start_run(14'h0100, 14'h0200, 8'd2);
      cyc = 0;
      while (!(PSELx === 1'b1 && PENABLE === 1'b1 && PADDR == 16'h0000) && cyc < 50) begin
         tick(1);
         cyc++;
      end
      chk("mid_reset_reached_data_access", 32'(PENABLE), 32'd1);
      PRESET = 1'b1;
      tick(1);
      chk("mid_rst_psel", 32'(PSELx), 32'd0);
      chk("mid_rst_penable", 32'(PENABLE), 32'd0);
      chk("mid_rst_pwrite", 32'(PWRITE), 32'd0);
      chk("mid_rst_paddr", 32'(PADDR), 32'd0);
      chk("mid_rst_pwdata", PWDATA, 32'd0);
      chk("mid_rst_flags", 32'({busy, done, err, data_ready}), 32'd0);
      chk("mid_rst_err_code", 32'(err_code), 32'd0);
      PRESET = 1'b0;
      stall_n = 0;
      data_valid = 1'b0;
      tick(3);
      chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("mid_rst_q_empty", 32'(exp_q.size()), 32'd0);

      // start while busy is dropped
      d0 = done_cnt;
      push(16'h0008, 32'h0000_3FFF);
      push(16'h0004, 32'h0000_0000);
      start_run(14'h3FFF, 14'h0000, '0);
      tick(1);
      tmo_value = 14'h1111;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      wait_end(50, cyc);
      chk("busy_start_done", 32'(done), 32'd1);
      tick(20);
      chk("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
      chk("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
